product_display: RTL
====================

Name: product_display

Overview:
- Downstream stage of the Booth multiplier datapath; consumes its 16-bit signed product when the controller asserts the display-load strobe.
- Converts the two's-complement product to sign plus 5 BCD digits using a sequential shift-add-3 (double-dabble) engine.
- Drives a 6-digit multiplexed common-anode seven-segment display by time-sliced scanning.

Parameters:
- SCAN_DIV, 16, clock cycles each digit is held before the scanner advances (minimum 2; small value for simulation).
- SCAN_W, 16, width of the scan prescaler counter; must satisfy 2^SCAN_W >= SCAN_DIV.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- product  in  16  signed two's-complement product from the multiplier.
- valid  in  1  level strobe from the multiplier: product is stable and must be displayed.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- an  out  6  digit anode enables, active-low; an[5] is the sign digit, an[4..0] run from ten-thousands down to units.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when new digits are committed.

Behaviour:
- Reset (reset=0, async) sets:
  - state=IDLE, busy=0, done=0.
  - all digit registers=0, sign register=0.
  - scan index=0, prescaler=0.
  - seg=7'b1111111, an=6'b111111.
- FSM states are IDLE, CONV, COMMIT.
- IDLE:
  - If valid=1 at an edge: latch sign=product[15]; latch magnitude = sign ? (~product+1) : product as 16-bit unsigned.
  - Clear the 20-bit BCD accumulator, set bit counter=16, go to CONV.
  - If valid=0, stay in IDLE.
- CONV:
  - Each edge: every BCD nibble >=5 gets +3, then {bcd,mag} shifts left 1; counter decrements.
  - After the 16th shift, go to COMMIT.
  - busy=1 throughout CONV and COMMIT.
- COMMIT:
  - done=1 for this single cycle.
  - On the exit edge, copy the 5 BCD nibbles and the sign into the display registers; go to IDLE.
- Latency: the capture edge is E0, shifts occur at E1..E16, digits are visible from edge E18.
- valid high during CONV/COMMIT is ignored; no queueing.
- valid still high on return to IDLE starts a new conversion of the current product. Repeating the same value is harmless.
- -32768 (0x8000) has magnitude 32768, which fits 16-bit unsigned; it must display "-32768".
- Zero: sign is always forced to 0, so there is no "-0".
- Scanner:
  - Free-running in every state, independent of the FSM.
  - Prescaler counts 0..SCAN_DIV-1; at wrap, the index increments 0..5 and then wraps to 0.
  - Index i drives an = ~(1<<i): index 0 = units digit, index 5 = sign digit.
  - seg is a registered decode of the selected digit, updated the same edge the index changes; exactly one anode is low at a time.
- Sign digit shows '-' (seg=7'b0111111) when negative, blank (7'b1111111) otherwise.
- Nibble decode:
  - Digits 0-9 use the standard active-low patterns (0=7'b1000000, 1=7'b1111001, 2=7'b0100100, ...).
  - Non-decimal nibbles show blank.
- Reset mid-conversion aborts immediately; the display returns to the reset contents.

Optional Feature:
- Macro PRODUCT_DISPLAY_BLANK_EN.
- Defined: leading zeros in the ten-thousands..tens digits are blanked; the units digit is never blanked. The '-' sign stays in an[5], not shifted next to the number.
- Undefined: all 5 digits are always shown, e.g. "000012".
- After reset with the macro defined, the display shows "     0".

Decomposition:
- Package product_display_pkg holds:
  - FSM state enum.
  - Seven-segment constants SEG_BLANK, SEG_MINUS and the 0-9 pattern array.
  - Constants NUM_DIGITS=6 and BCD_DIGITS=5.
- One sub-module, seg7_decode: a 4-bit nibble plus blank flag in, 7-bit active-low pattern out. It is purely combinational; the registering stays in the parent.

Test Plan:
- Reset asserted mid-scan -> seg=7'h7F, an=6'h3F, busy=0; after release, the units digit shows 0 within SCAN_DIV cycles.
- product=16'h000C, valid for one cycle -> busy for 17 cycles, one done pulse; digits read "000012" (or "    12" with the macro), sign blank.
- product=16'hFFF4 -> sign digit seg=7'b0111111; remaining digits read 00012.
- product=16'h8000 -> "-32768"; product=16'h7FFF -> "32767", sign blank.
- Second valid pulse with product=16'h0005 while busy -> ignored; display holds the first result and there is exactly one done pulse.
- Scan check with SCAN_DIV=4 -> an steps 111110, 111101, ..., 011111, 111110, each held exactly 4 cycles; one-hot-low on every cycle.

Source files
------------

// File: rtl/product_display_pkg.sv
// product_display_pkg: shared FSM states, segment patterns and digit counts for product_display.
package product_display_pkg;
   typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;
   localparam int NUM_DIGITS = 6;
   localparam int BCD_DIGITS = 5;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;
   localparam logic [6:0] SEG_DIGIT [10] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: BCD nibble to active-low {g..a} pattern; non-decimal or blanked nibbles go dark.
module seg7_decode
   import product_display_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       blank,
   output logic [6:0] seg
);
   always_comb seg = (blank || nibble > 4'd9) ? SEG_BLANK : SEG_DIGIT[nibble];
endmodule

// File: rtl/product_display.sv
// product_display: Booth product to sign + 5 BCD digits on a scanned 6-digit common-anode display.
// Define PRODUCT_DISPLAY_BLANK_EN to blank leading zeros (units digit always shown).
module product_display
   import product_display_pkg::*;
#(
   parameter int SCAN_DIV = 16,
   parameter int SCAN_W   = 16
)(
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] product,
   input  logic        valid,
   output logic [6:0]  seg,
   output logic [5:0]  an,
   output logic        busy,
   output logic        done
);
   state_t            state;
   logic [15:0]       mag;
   logic [19:0]       bcd, bcd_adj;
   logic [4:0]        cnt;
   logic              sign, neg;
   logic [3:0]        dig [BCD_DIGITS];
   logic [SCAN_W-1:0] pre;
   logic [2:0]        idx, nidx;
   logic [4:0]        lz;
   logic [3:0]        nib;
   logic              blk, wrap;
   logic [6:0]        dec;

   always_comb begin
      bcd_adj = bcd;
      for (int k = 0; k < BCD_DIGITS; k++)
         bcd_adj[k*4 +: 4] = bcd[k*4 +: 4] >= 4'd5 ? bcd[k*4 +: 4] + 4'd3 : bcd[k*4 +: 4];
   end

   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         mag   <= '0;
         bcd   <= '0;
         cnt   <= '0;
         sign  <= 1'b0;
         neg   <= 1'b0;
         for (int k = 0; k < BCD_DIGITS; k++) dig[k] <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (valid) begin
               sign  <= product[15];
               mag   <= product[15] ? ~product + 16'd1 : product;
               bcd   <= '0;
               cnt   <= 5'd16;
               busy  <= 1'b1;
               state <= CONV;
            end
            CONV: begin
               {bcd, mag} <= {bcd_adj[18:0], mag, 1'b0};
               cnt        <= cnt - 5'd1;
               if (cnt == 5'd1) begin
                  state <= COMMIT;
                  done  <= 1'b1;
               end
            end
            COMMIT: begin
               for (int k = 0; k < BCD_DIGITS; k++) dig[k] <= bcd[k*4 +: 4];
               neg   <= sign;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end

   // lz[k]: digit k and every digit above it are zero
   always_comb begin
      lz = '0;
`ifdef PRODUCT_DISPLAY_BLANK_EN
      lz[4] = dig[4] == 4'd0;
      for (int k = 3; k > 0; k--) lz[k] = lz[k+1] && dig[k] == 4'd0;
`endif
   end

   always_comb begin
      wrap = pre == SCAN_W'(SCAN_DIV - 1);
      nidx = wrap ? (idx == 3'(NUM_DIGITS - 1) ? 3'd0 : idx + 3'd1) : idx;
      nib  = nidx < 3'd5 ? dig[nidx] : 4'd0;
      blk  = nidx < 3'd5 ? lz[nidx] : 1'b0;
   end

   seg7_decode u_dec (.nibble(nib), .blank(blk), .seg(dec));

   // seg/an are refreshed every cycle from the index about to take effect
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         pre <= '0;
         idx <= '0;
         seg <= SEG_BLANK;
         an  <= 6'b111111;
      end else begin
         pre <= wrap ? '0 : pre + SCAN_W'(1);
         idx <= nidx;
         an  <= ~(6'd1 << nidx);
         seg <= nidx == 3'(NUM_DIGITS - 1) ? (neg ? SEG_MINUS : SEG_BLANK) : dec;
      end
endmodule
